// File: rtl/inert_intf_ctrl.sv
// Inertial sensor SPI controller: waits out power-up, configures the gyro,
// then reads yaw rate (and, with INERT_PTCH_EN, pitch rate) on each INT.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   INT                 async data-ready from the sensor
//   done, resp          SPI transaction-complete pulse and response word
//   snd, cmd            SPI start pulse and registered command word
//   init_done           sticky once configuration finishes
//   yaw_rt              signed yaw rate {high, low}
//   ptch_rt             signed pitch rate (only with INERT_PTCH_EN)
//   vld                 one-cycle pulse when new rate sample(s) are valid
//
// Build option: define INERT_PTCH_EN to add pitch-rate reads and ptch_rt.
module inert_intf_ctrl #(
  parameter int INIT_WAIT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic        init_done,
  output logic [15:0] yaw_rt,
`ifdef INERT_PTCH_EN
  output logic [15:0] ptch_rt,
`endif
  output logic        vld
);

  localparam logic [15:0] WAIT_VAL = 16'(INIT_WAIT);

  typedef enum logic [3:0] {
    INIT_WT,
    CFG_INT,
    CFG_GYRO,
    CFG_RND,
    IDLE,
    RD_YL,
    RD_YH
`ifdef INERT_PTCH_EN
    ,
    RD_PL,
    RD_PH
`endif
  } state_t;

  state_t      state;
  logic [15:0] timer;
  logic        int_s1;
  logic        int_s2;
  logic [7:0]  yaw_lo;
`ifdef INERT_PTCH_EN
  logic [7:0]  yaw_hi;
  logic [7:0]  ptch_lo;
`endif

  // Only the low response byte carries register data.
  logic unused_resp;
  assign unused_resp = ^resp[15:8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT_WT;
      timer     <= 16'h0000;
      snd       <= 1'b0;
      cmd       <= 16'h0000;
      init_done <= 1'b0;
      yaw_rt    <= 16'h0000;
      vld       <= 1'b0;
      int_s1    <= 1'b0;
      int_s2    <= 1'b0;
      yaw_lo    <= 8'h00;
`ifdef INERT_PTCH_EN
      ptch_rt   <= 16'h0000;
      yaw_hi    <= 8'h00;
      ptch_lo   <= 8'h00;
`endif
    end else begin
      snd    <= 1'b0;
      vld    <= 1'b0;
      int_s1 <= INT;
      int_s2 <= int_s1;
      unique case (state)
        INIT_WT: begin
          // Timer parks at the limit; the state change ends the wait.
          if (timer == WAIT_VAL) begin
            snd   <= 1'b1;
            cmd   <= 16'h0D02;
            state <= CFG_INT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        CFG_INT: if (done) begin
          snd   <= 1'b1;
          cmd   <= 16'h1160;
          state <= CFG_GYRO;
        end
        CFG_GYRO: if (done) begin
          snd   <= 1'b1;
          cmd   <= 16'h1440;
          state <= CFG_RND;
        end
        CFG_RND: if (done) begin
          init_done <= 1'b1;
          state     <= IDLE;
        end
        IDLE: if (int_s2) begin
          snd   <= 1'b1;
          cmd   <= 16'hA600;
          state <= RD_YL;
        end
        RD_YL: if (done) begin
          yaw_lo <= resp[7:0];
          snd    <= 1'b1;
          cmd    <= 16'hA700;
          state  <= RD_YH;
        end
`ifdef INERT_PTCH_EN
        RD_YH: if (done) begin
          yaw_hi <= resp[7:0];
          snd    <= 1'b1;
          cmd    <= 16'hA200;
          state  <= RD_PL;
        end
        RD_PL: if (done) begin
          ptch_lo <= resp[7:0];
          snd     <= 1'b1;
          cmd     <= 16'hA300;
          state   <= RD_PH;
        end
        RD_PH: if (done) begin
          yaw_rt  <= {yaw_hi, yaw_lo};
          ptch_rt <= {resp[7:0], ptch_lo};
          vld     <= 1'b1;
          state   <= IDLE;
        end
`else
        RD_YH: if (done) begin
          yaw_rt <= {resp[7:0], yaw_lo};
          vld    <= 1'b1;
          state  <= IDLE;
        end
`endif
        default: state <= INIT_WT;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_intf_ctrl.sv
// Directed bench for inert_intf_ctrl: reset, init wait, configuration,
// rate reads, back-to-back samples and reset mid-transaction.
module tb_inert_intf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] resp;
  logic        snd;
  logic [15:0] cmd;
  logic        init_done;
  logic [15:0] yaw_rt;
`ifdef INERT_PTCH_EN
  logic [15:0] ptch_rt;
`endif
  logic        vld;

  int checks = 0;
  int errors = 0;

  inert_intf_ctrl #(.INIT_WAIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .done      (done),
    .resp      (resp),
    .snd       (snd),
    .cmd       (cmd),
    .init_done (init_done),
    .yaw_rt    (yaw_rt),
`ifdef INERT_PTCH_EN
    .ptch_rt   (ptch_rt),
`endif
    .vld       (vld)
  );

  always #5 clk = ~clk;

  // Wait (bounded) for snd; reports cycles waited, 0 if it never came.
  task automatic wait_snd(input int lim, output int cyc);
    cyc = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (snd) begin
        cyc = i;
        break;
      end
    end
  endtask

  // SPI slave model: called on the negedge where snd is seen. Counts
  // cycles where snd reasserts or cmd moves while outstanding.
  task automatic spi_txn(input logic [15:0] r, input int lat,
                         output int bad);
    logic [15:0] c0;
    c0 = cmd;
    bad = 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (snd || cmd !== c0) bad++;
    end
    done = 1'b1;
    resp = r;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    INT = 1'b0;
    done = 1'b0;
    resp = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (snd !== 1'b0 || cmd !== 16'h0000 || init_done !== 1'b0 ||
        yaw_rt !== 16'h0000 || vld !== 1'b0) begin
      errors++;
      $display("FAIL reset: snd=%b cmd=%h init_done=%b yaw=%h vld=%b",
               snd, cmd, init_done, yaw_rt, vld);
    end
  endtask

  task automatic test_init_wait;
    int cyc;
    rst_n = 1'b1;
    wait_snd(40, cyc);
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL init_wait: snd after %0d cycles, need 17", cyc);
    end
    checks++;
    if (cmd !== 16'h0D02) begin
      errors++;
      $display("FAIL init_cmd: cmd=%h need 0d02", cmd);
    end
  endtask

  task automatic test_config;
    int bad;
    int tot;
    tot = 0;
    spi_txn(16'h0000, 40, bad);
    tot += bad;
    checks++;
    if (snd !== 1'b1 || cmd !== 16'h1160 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL cfg2: snd=%b cmd=%h init_done=%b need 1 1160 0",
               snd, cmd, init_done);
    end
    spi_txn(16'h0000, 40, bad);
    tot += bad;
    checks++;
    if (snd !== 1'b1 || cmd !== 16'h1440 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL cfg3: snd=%b cmd=%h init_done=%b need 1 1440 0",
               snd, cmd, init_done);
    end
    spi_txn(16'h0000, 40, bad);
    tot += bad;
    checks++;
    if (init_done !== 1'b1 || snd !== 1'b0) begin
      errors++;
      $display("FAIL cfg_done: init_done=%b snd=%b need 1 0",
               init_done, snd);
    end
    checks++;
    if (tot != 0) begin
      errors++;
      $display("FAIL cfg_hold: %0d snd/cmd glitches, need 0", tot);
    end
    // A stray done in IDLE must do nothing.
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (snd !== 1'b0 || vld !== 1'b0 || init_done !== 1'b1) begin
        errors++;
        $display("FAIL idle_done: snd=%b vld=%b init_done=%b",
                 snd, vld, init_done);
      end
    end
  endtask

  task automatic test_yaw_read;
    int cyc;
    int bad;
    int tot;
    tot = 0;
    INT = 1'b1;
    wait_snd(6, cyc);
    INT = 1'b0;
    checks++;
    if (cyc != 3 || cmd !== 16'hA600) begin
      errors++;
      $display("FAIL rd_start: cycles=%0d cmd=%h need 3 a600", cyc, cmd);
    end
    spi_txn(16'h0034, 40, bad);
    tot += bad;
    checks++;
    if (snd !== 1'b1 || cmd !== 16'hA700 || yaw_rt !== 16'h0000 ||
        vld !== 1'b0) begin
      errors++;
      $display("FAIL rd_yh: snd=%b cmd=%h yaw=%h vld=%b need 1 a700 0 0",
               snd, cmd, yaw_rt, vld);
    end
    spi_txn(16'h0012, 40, bad);
    tot += bad;
`ifdef INERT_PTCH_EN
    checks++;
    if (cmd !== 16'hA200 || yaw_rt !== 16'h0000 || vld !== 1'b0) begin
      errors++;
      $display("FAIL rd_pl: cmd=%h yaw=%h vld=%b need a200 0 0",
               cmd, yaw_rt, vld);
    end
    spi_txn(16'h00CD, 40, bad);
    tot += bad;
    checks++;
    if (cmd !== 16'hA300 || vld !== 1'b0) begin
      errors++;
      $display("FAIL rd_ph: cmd=%h vld=%b need a300 0", cmd, vld);
    end
    spi_txn(16'h00AB, 40, bad);
    tot += bad;
    checks++;
    if (ptch_rt !== 16'hABCD) begin
      errors++;
      $display("FAIL ptch: ptch_rt=%h need abcd", ptch_rt);
    end
`endif
    checks++;
    if (yaw_rt !== 16'h1234 || vld !== 1'b1) begin
      errors++;
      $display("FAIL yaw: yaw_rt=%h vld=%b need 1234 1", yaw_rt, vld);
    end
    @(negedge clk);
    checks++;
    if (vld !== 1'b0 || snd !== 1'b0 || tot != 0) begin
      errors++;
      $display("FAIL vld_pulse: vld=%b snd=%b glitches=%0d need 0 0 0",
               vld, snd, tot);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bad;
    int tot;
    int n;
    tot = 0;
    n = 2;
`ifdef INERT_PTCH_EN
    n = 4;
`endif
    INT = 1'b1;
    wait_snd(6, cyc);
    for (int s = 0; s < 3; s++) begin
      if (s == 2) INT = 1'b0;
      for (int k = 0; k < n; k++) begin
        spi_txn(16'(8'h10 * (s + 1) + k), 5 + k, bad);
        tot += bad;
      end
      checks++;
      if (vld !== 1'b1 ||
          yaw_rt !== {8'(8'h10 * (s + 1) + 1), 8'(8'h10 * (s + 1))}) begin
        errors++;
        $display("FAIL b2b_sample%0d: vld=%b yaw=%h", s, vld, yaw_rt);
      end
      if (s < 2) begin
        @(negedge clk);
        checks++;
        if (snd !== 1'b1 || cmd !== 16'hA600) begin
          errors++;
          $display("FAIL b2b_restart%0d: snd=%b cmd=%h need 1 a600",
                   s, snd, cmd);
        end
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (snd) tot++;
    end
    checks++;
    if (tot != 0) begin
      errors++;
      $display("FAIL b2b_overlap: %0d bad snd/cmd cycles, need 0", tot);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    INT = 1'b1;
    wait_snd(6, cyc);
    INT = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done = 1'b1;
    resp = 16'h0099;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (snd !== 1'b0 || yaw_rt !== 16'h0000 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: snd=%b yaw=%h init_done=%b need 0 0 0",
               snd, yaw_rt, init_done);
    end
    wait_snd(40, cyc);
    checks++;
    if (cyc != 16 || cmd !== 16'h0D02) begin
      errors++;
      $display("FAIL rst_mid_wait: snd after %0d+1 cycles cmd=%h need 17 0d02",
               cyc, cmd);
    end
  endtask

  initial begin
    test_reset();
    test_init_wait();
    test_config();
    test_yaw_read();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
